// File: rtl/instruction_reg.sv
// rtl/instruction_reg.sv - A32 instruction decode register
// Classifies IR into an instruction class and extracts its fields, all outputs registered.
module instruction_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    output logic [4:0]  inst,
    output logic        I,
    output logic        S,
    output logic [1:0]  stype,
    output logic [3:0]  addr_Rn,
    output logic [3:0]  addr_Rd,
    output logic [3:0]  addr_Rm,
    output logic [3:0]  addr_Rs,
    output logic [4:0]  imm_shift,
    output logic [11:0] imm_OP_2,
    output logic        br_L,
    output logic [23:0] br_offset,
    output logic [1:0]  imod,
    output logic        M,
    output logic        A,
    output logic        IRQ,
    output logic        FIQ,
    output logic [4:0]  mode,
    output logic [4:0]  single_trans_f
);

    localparam logic [4:0] INST_MOV_LAS = 5'h10;
    localparam logic [4:0] INST_BRANCH  = 5'h11;
    localparam logic [4:0] INST_LDST    = 5'h12;
    localparam logic [4:0] INST_CPS     = 5'h13;
    localparam logic [4:0] INST_NOP     = 5'h1F;

    typedef struct packed {
        logic [4:0]  inst;
        logic        i;
        logic        s;
        logic [1:0]  stype;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [4:0]  shamt;
        logic [11:0] op2;
        logic        br_l;
        logic [23:0] br_off;
        logic [1:0]  imod;
        logic        m;
        logic        a;
        logic        irq;
        logic        fiq;
        logic [4:0]  mode;
        logic [4:0]  stf;
    } dec_t;

    localparam dec_t DEC_NOP = '{inst: INST_NOP, default: '0};

    dec_t w_dec;
    dec_t r_dec;
    logic w_is_cps;
    logic w_is_dp;

    assign w_is_cps = (IR[31:20] == 12'hF10) && !IR[5];
    // Register-operand forms with IR[7] and IR[4] both set are multiply/extra
    // load-store space, which this decoder does not support.
    assign w_is_dp  = (IR[27:26] == 2'b00) && !(!IR[25] && IR[7] && IR[4]);

    always_comb begin
        w_dec = DEC_NOP;
        if (w_is_cps) begin
            w_dec.inst = INST_CPS;
            w_dec.imod = IR[19:18];
            w_dec.m    = IR[17];
            w_dec.a    = IR[8];
            w_dec.irq  = IR[7];
            w_dec.fiq  = IR[6];
            w_dec.mode = IR[4:0];
        end else if (IR[31:28] == 4'hF) begin
            w_dec = DEC_NOP;
        end else if (IR[27:25] == 3'b101) begin
            w_dec.inst   = INST_BRANCH;
            w_dec.br_l   = IR[24];
            w_dec.br_off = IR[23:0];
        end else if (IR[27:26] == 2'b01) begin
            w_dec.inst = INST_LDST;
            w_dec.i    = IR[25];
            w_dec.stf  = IR[24:20];
            w_dec.rn   = IR[19:16];
            w_dec.rd   = IR[15:12];
            w_dec.op2  = IR[11:0];
            if (IR[25]) begin
                w_dec.rm    = IR[3:0];
                w_dec.stype = IR[6:5];
                w_dec.shamt = IR[11:7];
            end
        end else if (w_is_dp) begin
            w_dec.inst = {1'b0, IR[24:21]};
            w_dec.s    = IR[20];
            w_dec.rn   = IR[19:16];
            w_dec.rd   = IR[15:12];
            w_dec.op2  = IR[11:0];
            if (IR[25]) begin
                w_dec.i = 1'b1;
            end else begin
                w_dec.rm    = IR[3:0];
                w_dec.stype = IR[6:5];
                if (IR[4]) begin
                    w_dec.rs = IR[11:8];
                end else begin
                    w_dec.shamt = IR[11:7];
                end
                // Register MOV gets its own class; I then distinguishes immediate vs Rs shift.
                if (IR[24:21] == 4'b1101) begin
                    w_dec.inst = INST_MOV_LAS;
                    w_dec.i    = ~IR[4];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec <= DEC_NOP;
        end else begin
            r_dec <= w_dec;
        end
    end

    assign inst           = r_dec.inst;
    assign I              = r_dec.i;
    assign S              = r_dec.s;
    assign stype          = r_dec.stype;
    assign addr_Rn        = r_dec.rn;
    assign addr_Rd        = r_dec.rd;
    assign addr_Rm        = r_dec.rm;
    assign addr_Rs        = r_dec.rs;
    assign imm_shift      = r_dec.shamt;
    assign imm_OP_2       = r_dec.op2;
    assign br_L           = r_dec.br_l;
    assign br_offset      = r_dec.br_off;
    assign imod           = r_dec.imod;
    assign M              = r_dec.m;
    assign A              = r_dec.a;
    assign IRQ            = r_dec.irq;
    assign FIQ            = r_dec.fiq;
    assign mode           = r_dec.mode;
    assign single_trans_f = r_dec.stf;

endmodule

// File: tb/tb_instruction_reg.sv
// tb/tb_instruction_reg.sv - self-checking bench for instruction_reg
// Table of IR words with hand-derived expected decodes, checked through a scoreboard queue.
module tb_instruction_reg;

    typedef struct packed {
        logic [4:0]  inst;
        logic        i;
        logic        s;
        logic [1:0]  stype;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [4:0]  sh;
        logic [11:0] imm;
        logic        brl;
        logic [23:0] off;
        logic [1:0]  imod;
        logic        m;
        logic        a;
        logic        irq;
        logic        fiq;
        logic [4:0]  mode;
        logic [4:0]  stf;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IR  = 32'hE2811005;
    logic [4:0]  inst;
    logic        I, S, br_L, M, A, IRQ, FIQ;
    logic [1:0]  stype, imod;
    logic [3:0]  addr_Rn, addr_Rd, addr_Rm, addr_Rs;
    logic [4:0]  imm_shift, mode, single_trans_f;
    logic [11:0] imm_OP_2;
    logic [23:0] br_offset;

    exp_t act;
    exp_t e;
    exp_t sb_q[$];
    vec_t tv[$];
    int   n_pass = 0;
    int   n_total = 0;

    instruction_reg dut (
        .clk(clk), .rst(rst), .IR(IR), .inst(inst), .I(I), .S(S), .stype(stype),
        .addr_Rn(addr_Rn), .addr_Rd(addr_Rd), .addr_Rm(addr_Rm), .addr_Rs(addr_Rs),
        .imm_shift(imm_shift), .imm_OP_2(imm_OP_2), .br_L(br_L), .br_offset(br_offset),
        .imod(imod), .M(M), .A(A), .IRQ(IRQ), .FIQ(FIQ), .mode(mode),
        .single_trans_f(single_trans_f)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '0;
        act.inst = inst;       act.i = I;            act.s = S;
        act.stype = stype;     act.rn = addr_Rn;     act.rd = addr_Rd;
        act.rm = addr_Rm;      act.rs = addr_Rs;     act.sh = imm_shift;
        act.imm = imm_OP_2;    act.brl = br_L;       act.off = br_offset;
        act.imod = imod;       act.m = M;            act.a = A;
        act.irq = IRQ;         act.fiq = FIQ;        act.mode = mode;
        act.stf = single_trans_f;
    end

    function automatic exp_t nop_e();
        exp_t r;
        r = '0;
        r.inst = 5'h1F;
        return r;
    endfunction

    task automatic check(input string nm, input exp_t ex);
        n_total++;
        if (act !== ex)
            $display("FAIL %s: got=%h expected=%h", nm, act, ex);
        else
            n_pass++;
    endtask

    task automatic add(input logic [31:0] ir, input exp_t ex);
        vec_t v;
        v.ir = ir;
        v.exp = ex;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [31:0] ir, input exp_t ex);
        @(negedge clk);
        IR = ir;
        sb_q.push_back(ex);
    endtask

    task automatic pop_check(input string nm);
        exp_t ex;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            ex = sb_q.pop_front();
            check(nm, ex);
        end
    endtask

    initial begin
        e = nop_e(); e.inst = 5'h04; e.i = 1; e.rn = 1; e.rd = 1; e.imm = 12'h005;
        add(32'hE2811005, e);
        e = nop_e(); e.inst = 5'h10; e.i = 1; e.stype = 2'b01; e.sh = 5'd2; e.rm = 1; e.rd = 1; e.imm = 12'h121;
        add(32'hE1A01121, e);
        e = nop_e(); e.inst = 5'h10; e.stype = 2'b01; e.rs = 2; e.rm = 1; e.rd = 1; e.imm = 12'h231;
        add(32'hE1A01231, e);
        e = nop_e(); e.inst = 5'h11; e.brl = 1; e.off = 24'h000010;
        add(32'hEB000010, e);
        e = nop_e(); e.inst = 5'h12; e.stf = 5'b11001; e.rn = 1; e.rd = 2; e.imm = 12'h004;
        add(32'hE5912004, e);
        e = nop_e(); e.inst = 5'h13; e.imod = 2'b11; e.irq = 1;
        add(32'hF10C0080, e);
        add(32'hF0000000, nop_e());
        e = nop_e(); e.inst = 5'h04; e.s = 1; e.rn = 1; e.rd = 2; e.rs = 3; e.rm = 4; e.imm = 12'h314;
        add(32'hE0912314, e);
        add(32'hE0000090, nop_e());
        e = nop_e(); e.inst = 5'h12; e.i = 1; e.stf = 5'b11001; e.rn = 3; e.rd = 2; e.rm = 5;
        e.sh = 5'd2; e.stype = 2'b10; e.imm = 12'h145;
        add(32'h07932145, e);
        add(32'hF10C00A0, nop_e());
        add(32'hEE000000, nop_e());
        e = nop_e(); e.inst = 5'h0D; e.i = 1; e.rd = 1; e.imm = 12'h00F;
        add(32'hE3A0100F, e);
        e = nop_e(); e.inst = 5'h11; e.off = 24'hFFFFFE;
        add(32'h0AFFFFFE, e);
        e = nop_e(); e.inst = 5'h04; e.rn = 3; e.rd = 2; e.rm = 3; e.sh = 5'd20; e.stype = 2'b10; e.imm = 12'hA43;
        add(32'hE0832A43, e);
        e = nop_e(); e.inst = 5'h13; e.m = 1; e.a = 1; e.irq = 1; e.fiq = 1; e.mode = 5'h13;
        add(32'hF10201D3, e);

        #2 rst = 1'b0;
        #1 check("reset_async", nop_e());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_hold_after_release", nop_e());

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].ir, tv[k].exp);
            pop_check($sformatf("vec%0d_%h", k, tv[k].ir));
        end

        drive(32'hE2811005, tv[0].exp);
        pop_check("pre_midreset");
        #2 rst = 1'b0;
        #1 check("midreset_discard", nop_e());
        @(posedge clk);
        #1 check("midreset_hold", nop_e());
        @(negedge clk);
        rst = 1'b1;
        IR = 32'hEB000010;
        sb_q.push_back(tv[3].exp);
        pop_check("post_reset_branch");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
